seq_add_sub: RTL and testbench

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/seq_add_pkg.sv | 18 +
 rtl/chunk_add.sv | 31 +++
 rtl/seq_add_sub.sv | 113 +++++++++++
 tb/tb_seq_add_sub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_add_pkg.sv
// Shared constants for the sequential chunked adder/subtractor.
//   - FSM state encoding (IDLE/CALC/DONE)
//   - default operand width and chunk size
package seq_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter width for n chunks, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder.
// Ports:
//   a, b   : CHUNK-bit addends
//   c_in   : carry in
//   sum    : CHUNK-bit sum
//   c_out  : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow)
module chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// Sequential add/subtract: one CHUNK-bit slice per cycle, LSB chunk first,
// through a single shared chunk_add. Result after WIDTH/CHUNK cycles.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   x, y, sub, c_in     : operands; sub=1 gives x-y-c_in (c_in is borrow)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, c_out, of      : result, raw carry out (sub: 0 = borrow), signed ovf
//   zero                : sum==0 flag, present only with SEQ_ADD_SUB_ZERO_FLAG_EN
module seq_add_sub
  import seq_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             of
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
  ,output logic            zero
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = cnt_w(NCH);
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  logic [1:0]                  state;
  logic [KW-1:0]               k;
  logic [NCH-1:0][CHUNK-1:0]   x_r, y_r, sum_r, sum_nxt;
  logic                        carry;
  logic                        c_out_r, of_r;
  logic [CHUNK-1:0]            ch_sum;
  logic                        ch_cout, ch_cmsb;

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a     (x_r[k]),
    .b     (y_r[k]),
    .c_in  (carry),
    .sum   (ch_sum),
    .c_out (ch_cout),
    .c_msb (ch_cmsb)
  );

  // Sum with the current chunk merged in; lets the zero flag see the
  // complete result on the same edge the last chunk is written.
  always_comb begin
    sum_nxt    = sum_r;
    sum_nxt[k] = ch_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      x_r     <= '0;
      y_r     <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      c_out_r <= 1'b0;
      of_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtraction as x + ~y + 1; borrow-in removes the +1.
          x_r   <= x;
          y_r   <= y ^ {WIDTH{sub}};
          carry <= c_in ^ sub;
          k     <= '0;
          state <= CALC;
        end
        CALC: begin
          sum_r <= sum_nxt;
          carry <= ch_cout;
          k     <= k + KW'(1);
          if (k == K_LAST) begin
            c_out_r <= ch_cout;
            of_r    <= ch_cmsb ^ ch_cout;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
  logic zero_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         zero_r <= 1'b0;
    else if (state == CALC && k == K_LAST) zero_r <= (sum_nxt == '0);
  end
  assign zero = zero_r;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign of        = of_r;

endmodule

// File: tb/tb_seq_add_sub.sv
module tb_seq_add_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit / 8-bit chunk instance
  logic        in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, of;
  logic [31:0] x, y, sum;
  // 8-bit single-chunk instance
  logic        v8_in_valid, v8_in_ready, v8_sub, v8_c_in, v8_out_valid, v8_out_ready, v8_c_out, v8_of;
  logic [7:0]  v8_x, v8_y, v8_sum;
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
  logic zero, v8_zero;
`endif

  seq_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .of(of)
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  seq_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .x(v8_x), .y(v8_y), .sub(v8_sub), .c_in(v8_c_in), .out_valid(v8_out_valid),
    .out_ready(v8_out_ready), .sum(v8_sum), .c_out(v8_c_out), .of(v8_of)
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
    , .zero(v8_zero)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one 32-bit op; returns edges from accept to out_valid.
  task automatic op32(input logic [31:0] xa, input logic [31:0] ya,
                      input logic s, input logic ci, output int lat);
    @(negedge clk);
    x = xa; y = ya; sub = s; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume32();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] xa, input logic [7:0] ya, output int lat);
    @(negedge clk);
    v8_x = xa; v8_y = ya; v8_sub = 1'b0; v8_c_in = 1'b0; v8_in_valid = 1'b1;
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    lat = 0;
    while (!v8_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; sub = 0; c_in = 0; x = '0; y = '0;
    v8_in_valid = 0; v8_out_ready = 0; v8_sub = 0; v8_c_in = 0; v8_x = '0; v8_y = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_of", of, 0);
    @(negedge clk); rst_n = 1'b1;

    // signed overflow on add
    op32(32'h7FFF_FFFF, 32'd1, 0, 0, lat);
    chk("ovf_lat", lat, 4);
    chk("ovf_sum", sum, 32'h8000_0000);
    chk("ovf_c_out", c_out, 0);
    chk("ovf_of", of, 1);
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
    chk("ovf_zero", zero, 0);
`endif
    consume32();

    // unsigned wrap to zero
    op32(32'hFFFF_FFFF, 32'd1, 0, 0, lat);
    chk("wrap_lat", lat, 4);
    chk("wrap_sum", sum, 0);
    chk("wrap_c_out", c_out, 1);
    chk("wrap_of", of, 0);
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
    chk("wrap_zero", zero, 1);
`endif
    consume32();

    // 5 - 7: borrow
    op32(32'd5, 32'd7, 1, 0, lat);
    chk("sub_neg_sum", sum, 32'hFFFF_FFFE);
    chk("sub_neg_c_out", c_out, 0);
    chk("sub_neg_of", of, 0);
    consume32();

    // min_int - 1: signed overflow, no borrow
    op32(32'h8000_0000, 32'd1, 1, 0, lat);
    chk("sub_ovf_sum", sum, 32'h7FFF_FFFF);
    chk("sub_ovf_c_out", c_out, 1);
    chk("sub_ovf_of", of, 1);
    consume32();

    // carry-in and borrow-in
    op32(32'd10, 32'd20, 0, 1, lat);
    chk("cin_sum", sum, 32'd31);
    chk("cin_c_out", c_out, 0);
    consume32();
    op32(32'd10, 32'd3, 1, 1, lat);
    chk("bin_sum", sum, 32'd6);
    chk("bin_c_out", c_out, 1);
    chk("bin_of", of, 0);
    consume32();

    // stall in DONE with a pending request
    op32(32'd100, 32'd23, 0, 0, lat);
    @(negedge clk);
    x = 32'd1; y = 32'd2; sub = 0; c_in = 0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_sum", sum, 32'd123);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("pend_accept", in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("pend_lat", lat, 4);
    chk("pend_sum", sum, 32'd3);
    consume32();

    // reset in the middle of CALC (k=2)
    @(negedge clk);
    x = 32'h0000_AAAA; y = 32'h0000_1111; sub = 0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_c_out", c_out, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_valid", out_valid, 0);
    op32(32'd3, 32'd4, 0, 0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_sum", sum, 32'd7);
    consume32();

    // single-chunk instance
    op8(8'h80, 8'h80, lat);
    chk("w8_lat", lat, 1);
    chk("w8_sum", v8_sum, 8'h00);
    chk("w8_c_out", v8_c_out, 1);
    chk("w8_of", v8_of, 1);
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
    chk("w8_zero", v8_zero, 1);
`endif
    @(negedge clk); v8_out_ready = 1'b1;
    @(posedge clk); #1; v8_out_ready = 1'b0;
    op8(8'h7F, 8'h01, lat);
    chk("w8b_sum", v8_sum, 8'h80);
    chk("w8b_c_out", v8_c_out, 0);
    chk("w8b_of", v8_of, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
